// File: rtl/maxnet_feeder_if.sv
// maxnet_feeder_if
//   Bundles the three handshakes around maxnet_feeder: the upstream operand
//   stream, the Maxnet operand/start/done side and the downstream result stream.
//   master : the feeder (drives in_ready, a0..a3, start, out_*, busy)
//   slave  : the surrounding environment (drives in_valid/in_data, mx_*, out_ready)
//   WIDTH  : operand and result width, must match Maxnet.
interface maxnet_feeder_if #(
    parameter int unsigned WIDTH = 5
);
    // upstream operand stream
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    // Maxnet side
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] a3;
    logic             start;
    logic             mx_done;
    logic [WIDTH-1:0] mx_result;
    // downstream result stream
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_index;
    logic             out_err;
    logic             out_ready;
    logic             busy;

    modport master (
        input  in_valid, in_data, mx_done, mx_result, out_ready,
        output in_ready, a0, a1, a2, a3, start,
               out_valid, out_data, out_index, out_err, busy
    );

    modport slave (
        output in_valid, in_data, mx_done, mx_result, out_ready,
        input  in_ready, a0, a1, a2, a3, start,
               out_valid, out_data, out_index, out_err, busy
    );
endinterface

// File: rtl/maxnet_feeder.sv
// maxnet_feeder
//   Initiator-side sequencer for the Maxnet winner-take-all block. Loads four
//   operands from a valid/ready stream into a0..a3, pulses start, waits for
//   mx_done, then returns the winning value and the lowest matching lane index
//   over a second valid/ready handshake. One frame in flight at a time.
//
//   Ports:
//     clk  : single clock, rising edge
//     rst  : asynchronous, active-low reset
//     bus  : maxnet_feeder_if.master (operand stream, Maxnet side, result stream)
//   Parameters:
//     WIDTH   : operand/result width
//     TIMEOUT : WAIT cycles before abort (only with MAXNET_TIMEOUT_EN)
//   Build option:
//     MAXNET_TIMEOUT_EN : when defined, WAIT aborts after TIMEOUT cycles
//                         without mx_done, returning data 0 with out_err set.
module maxnet_feeder #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst,
    maxnet_feeder_if.master bus
);

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        OUT
    } state_t;

    state_t           state_q;
    logic [1:0]       cnt_q;
    logic [WIDTH-1:0] a_q [4];
    logic             in_ready_q;
    logic             start_q;
    logic             busy_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [1:0]       out_index_q;
    logic             out_err_q;

    logic [1:0]       idx_d;
    logic             match_d;

`ifdef MAXNET_TIMEOUT_EN
    // Counter only ever holds 0..TIMEOUT-1.
    localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    logic [WCNT_W-1:0] wait_cnt_q;
`endif

    // Lowest lane whose operand equals the Maxnet result; lane 0 if none.
    always_comb begin
        idx_d   = '0;
        match_d = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!match_d && a_q[i] == bus.mx_result) begin
                idx_d   = 2'(i);
                match_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                a_q[i] <= '0;
            end
            in_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_err_q   <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    // in_ready is registered, so it rises on the first edge
                    // after reset release rather than during reset.
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        a_q[cnt_q] <= bus.in_data;
                        if (cnt_q == 2'd3) begin
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            start_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= START;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end

                START: begin
                    start_q <= 1'b0;
                    state_q <= WAIT;
`ifdef MAXNET_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end

                WAIT: begin
                    // mx_done takes priority over a coincident timeout.
                    if (bus.mx_done) begin
                        out_data_q  <= bus.mx_result;
                        out_index_q <= idx_d;
                        out_err_q   <= ~match_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= OUT;
                    end
`ifdef MAXNET_TIMEOUT_EN
                    else if (wait_cnt_q == WCNT_LAST) begin
                        out_data_q  <= '0;
                        out_index_q <= '0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= OUT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
                    end
`endif
                end

                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= LOAD;
                    end
                end

                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.a0        = a_q[0];
    assign bus.a1        = a_q[1];
    assign bus.a2        = a_q[2];
    assign bus.a3        = a_q[3];
    assign bus.start     = start_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_err   = out_err_q;

endmodule
